uart_rx: RTL and testbench

// - UART receiver: the receive side of the UART link. It recovers 8N1 (1 start,

---
 rtl/uart_rx_if.sv | 20 ++
 rtl/uart_rx.sv | 137 +++++++++++++
 tb/tb_uart_rx.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Received-byte valid/ready holding-register bus between the UART receiver and its consumer.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver on an external oversampling tick; byte valid the clk after the stop-bit sample.
// No backpressure on the line: an unconsumed byte is overwritten and overrun pulses.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      sample_tick,
  input  logic      rx,
  uart_rx_if.master bus,
  output logic      busy,
  output logic      frame_err,
  output logic      overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic [2:0]           state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_meta;
  logic                 rx_s;

  // Synchroniser resets to the idle (high) line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      if (bus.rx_valid && bus.rx_ready) begin
        bus.rx_valid <= 1'b0;
      end

      if (sample_tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end

          START: begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end

          DATA: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
              if (bit_cnt == BIT_LAST) begin
                state <= STOP;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end

          STOP: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              if (rx_s) begin
                // A new byte wins over a same-cycle accept; overrun only if nobody took the old one.
                bus.rx_data  <= shreg;
                bus.rx_valid <= 1'b1;
                overrun      <= bus.rx_valid & ~bus.rx_ready;
                state        <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= BREAK;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end

          BREAK: begin
            if (rx_s) begin
              state <= IDLE;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: vector table of whole frames plus hand sequences for glitch, back-to-back and mid-frame reset.
module tb_uart_rx;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sample_tick = 1'b0;
  logic rx = 1'b1;
  logic busy;
  logic frame_err;
  logic overrun;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .rx          (rx),
    .bus         (bus),
    .busy        (busy),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // One tick every 4 clocks; ncnt counts negedges and is read by stimulus 1 time unit later.
  int ncnt = 0;
  always @(negedge clk) begin
    ncnt = ncnt + 1;
    sample_tick = (ncnt % 4 == 0);
  end

  // Running totals of pulse-high cycles and valid rises; tests compare deltas.
  int   ferr_cyc = 0;
  int   ovr_cyc = 0;
  int   rises = 0;
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (frame_err) ferr_cyc = ferr_cyc + 1;
    if (overrun) ovr_cyc = ovr_cyc + 1;
    if (bus.rx_valid && !prev_valid) rises = rises + 1;
    prev_valid = bus.rx_valid;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int nbits);
    rx = 1'b1;
    bus.rx_ready = 1'b0;
    repeat (64 * nbits) step();
  endtask

  // Frame starts on a tick-aligned step n0; detection lands at n0+4, stop sample at n0+612.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int ack_at, input logic probe);
    while (ncnt % 4 != 0) step();
    for (int s = 0; s < 640; s++) begin
      automatic int b = s / 64;
      if (b == 0) rx = 1'b0;
      else if (b <= 8) rx = d[b-1];
      else rx = stop;
      bus.rx_ready = (s == ack_at);
      if (probe && s == 612) chk("lat_pre_valid", bus.rx_valid, 0);
      if (probe && s == 613) begin
        chk("lat_valid", bus.rx_valid, 1);
        chk("lat_data", bus.rx_data, d);
      end
      step();
    end
    bus.rx_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] dat;
    logic       stop;
    logic       ack;
    logic       probe;
    logic [7:0] exp_data;
    logic       exp_valid;
    int         exp_rise;
    int         exp_ferr;
    int         exp_ovr;
  } vec_t;

  vec_t vt[9];

  initial begin
    int fb, ob, rb;

    vt[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1, 0, 0};
    vt[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 0, 1, 0};
    vt[2] = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1, 0, 0};
    vt[3] = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1, 0, 0};
    vt[4] = '{8'h22, 1'b1, 1'b1, 1'b0, 8'h22, 1'b1, 0, 0, 1};
    vt[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 8'h80, 1'b1, 1, 0, 0};
    vt[6] = '{8'h01, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1, 0, 0};
    vt[7] = '{8'h7E, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 0, 1, 0};
    vt[8] = '{8'hE7, 1'b1, 1'b1, 1'b0, 8'hE7, 1'b1, 0, 0, 1};

    bus.rx_ready = 1'b0;
    reset = 1'b0;
    rx = 1'b1;
    repeat (4) step();
    chk("rst_data", bus.rx_data, 0);
    chk("rst_valid", bus.rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    reset = 1'b1;
    idle(1);

    for (int i = 0; i < 9; i++) begin
      fb = ferr_cyc; ob = ovr_cyc; rb = rises;
      send_frame(vt[i].dat, vt[i].stop, -1, vt[i].probe);
      if (!vt[i].stop) begin
        rx = 1'b0;
        repeat (192) step();
        chk("brk_busy", busy, 1);
      end
      idle(2);
      chk("vec_data", bus.rx_data, vt[i].exp_data);
      chk("vec_valid", bus.rx_valid, vt[i].exp_valid);
      chk("vec_busy", busy, 0);
      chk("vec_rise", rises - rb, vt[i].exp_rise);
      chk("vec_ferr", ferr_cyc - fb, vt[i].exp_ferr);
      chk("vec_ovr", ovr_cyc - ob, vt[i].exp_ovr);
      if (vt[i].ack) begin
        bus.rx_ready = 1'b1;
        step();
        bus.rx_ready = 1'b0;
        chk("ack_clr", bus.rx_valid, 0);
      end
    end

    // Short low pulse on an idle line: START, then rejected at the bit centre.
    fb = ferr_cyc; ob = ovr_cyc; rb = rises;
    rx = 1'b0;
    repeat (16) step();
    chk("glitch_busy", busy, 1);
    idle(2);
    chk("glitch_idle", busy, 0);
    chk("glitch_valid", bus.rx_valid, 0);
    chk("glitch_ferr", ferr_cyc - fb, 0);
    chk("glitch_ovr", ovr_cyc - ob, 0);
    chk("glitch_rise", rises - rb, 0);

    // Back-to-back frames, accept raised only on the second completion cycle.
    fb = ferr_cyc; ob = ovr_cyc; rb = rises;
    send_frame(8'h00, 1'b1, -1, 1'b0);
    send_frame(8'hFF, 1'b1, 612, 1'b0);
    idle(1);
    chk("b2b_data", bus.rx_data, 8'hFF);
    chk("b2b_valid", bus.rx_valid, 1);
    chk("b2b_ovr", ovr_cyc - ob, 0);
    chk("b2b_rise", rises - rb, 1);
    chk("b2b_ferr", ferr_cyc - fb, 0);
    bus.rx_ready = 1'b1;
    step();
    bus.rx_ready = 1'b0;

    // Hold a byte, then reset in the middle of data bit 3 of the next frame.
    send_frame(8'hC3, 1'b1, -1, 1'b0);
    idle(1);
    chk("pre_rst_valid", bus.rx_valid, 1);
    while (ncnt % 4 != 0) step();
    for (int s = 0; s < 280; s++) begin
      automatic int b = s / 64;
      automatic logic [7:0] d = 8'h96;
      if (b == 0) rx = 1'b0;
      else rx = d[b-1];
      step();
    end
    chk("mid_busy", busy, 1);
    reset = 1'b0;
    step();
    chk("mrst_data", bus.rx_data, 0);
    chk("mrst_valid", bus.rx_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ferr", frame_err, 0);
    chk("mrst_ovr", overrun, 0);
    reset = 1'b1;
    idle(3);
    chk("post_rst_idle", busy, 0);
    ob = ovr_cyc;
    send_frame(8'h5A, 1'b1, -1, 1'b1);
    idle(1);
    chk("post_rst_data", bus.rx_data, 8'h5A);
    chk("post_rst_valid", bus.rx_valid, 1);
    chk("post_rst_ovr", ovr_cyc - ob, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
